frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader.sv | 173 +++++++++++++++++
 tb/tb_frame_reader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// Avalon-MM burst read master that streams a block of 64-bit words from SDRAM through an output FIFO.
// Optional macro FRAME_READER_LOOP_EN: replay the latched pass forever until reset.
module frame_reader #(
   parameter int unsigned BURST_LEN  = 16,
   parameter int unsigned FIFO_DEPTH = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [28:0] base_address,
   input  logic [23:0] word_count,
   output logic        busy,
   output logic        done,
   output logic [28:0] address,
   output logic [7:0]  burstcount,
   output logic        read,
   input  logic        waitrequest,
   input  logic [63:0] readdata,
   input  logic        readdatavalid,
   output logic [63:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CMD, DRAIN} state_t;

   state_t        state_q;
   logic          read_q;
   logic [28:0]   address_q;
   logic [7:0]    burstcount_q;
   logic          busy_q;
   logic          zero_done_q;
   logic [28:0]   next_addr_q;
   logic [23:0]   issue_rem_q;
   logic [23:0]   deliver_rem_q;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [63:0]   fifo_mem [FIFO_DEPTH];
`ifdef FRAME_READER_LOOP_EN
   logic [28:0]   base_q;
   logic [23:0]   count_q;
`endif

   logic          beat_ok;
   logic          pop;
   logic          cmd_accept;
   logic          last_pop;
   logic          credit_ok;
   logic [7:0]    burst_len;
   logic [31:0]   credit;

   assign out_valid  = (fifo_cnt_q != '0);
   assign out_data   = fifo_mem[rd_ptr_q];
   assign read       = read_q;
   assign address    = address_q;
   assign burstcount = burstcount_q;
   assign busy       = busy_q;
   assign done       = zero_done_q | last_pop;

   always_comb begin
      // Beats with nothing outstanding are stale (e.g. from an aborted pass) and are discarded.
      beat_ok    = readdatavalid && (outstanding_q != '0);
      pop        = out_valid && out_ready;
      cmd_accept = read_q && !waitrequest;
      last_pop   = busy_q && pop && (deliver_rem_q == 24'd1);
      burst_len  = (issue_rem_q >= 24'(BURST_LEN)) ? 8'(BURST_LEN) : issue_rem_q[7:0];
      // FIFO occupancy plus words in flight never exceeds the depth, so this cannot underflow.
      credit     = 32'(FIFO_DEPTH) - 32'(fifo_cnt_q) - 32'(outstanding_q);
      credit_ok  = (credit >= 32'(burst_len));
      outstanding_d = outstanding_q
                    + (cmd_accept ? CW'(burstcount_q) : '0)
                    - (beat_ok ? CW'(1) : '0);
      fifo_cnt_d = fifo_cnt_q + CW'(beat_ok) - CW'(pop);
   end

   always_ff @(posedge clock) begin
      if (beat_ok) begin
         fifo_mem[wr_ptr_q] <= readdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         read_q        <= 1'b0;
         address_q     <= '0;
         burstcount_q  <= '0;
         busy_q        <= 1'b0;
         zero_done_q   <= 1'b0;
         next_addr_q   <= '0;
         issue_rem_q   <= '0;
         deliver_rem_q <= '0;
         outstanding_q <= '0;
         fifo_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
`ifdef FRAME_READER_LOOP_EN
         base_q        <= '0;
         count_q       <= '0;
`endif
      end else begin
         zero_done_q   <= 1'b0;
         outstanding_q <= outstanding_d;
         fifo_cnt_q    <= fifo_cnt_d;
         if (beat_ok) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (pop && (deliver_rem_q != '0)) begin
            deliver_rem_q <= deliver_rem_q - 24'd1;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  if (word_count == '0) begin
                     zero_done_q <= 1'b1;
                  end else begin
                     busy_q        <= 1'b1;
                     state_q       <= ISSUE;
                     next_addr_q   <= base_address;
                     issue_rem_q   <= word_count;
                     deliver_rem_q <= word_count;
`ifdef FRAME_READER_LOOP_EN
                     base_q        <= base_address;
                     count_q       <= word_count;
`endif
                  end
               end
            end
            ISSUE: begin
               if (credit_ok) begin
                  read_q       <= 1'b1;
                  address_q    <= next_addr_q;
                  burstcount_q <= burst_len;
                  state_q      <= WAIT_CMD;
               end
            end
            WAIT_CMD: begin
               if (!waitrequest) begin
                  read_q      <= 1'b0;
                  next_addr_q <= next_addr_q + 29'(burstcount_q);
                  issue_rem_q <= issue_rem_q - 24'(burstcount_q);
                  state_q     <= (issue_rem_q == 24'(burstcount_q)) ? DRAIN : ISSUE;
               end
            end
            DRAIN: begin
            end
            default: state_q <= IDLE;
         endcase

         // The final word can only leave once every burst was accepted, i.e. while draining.
         if (last_pop) begin
`ifdef FRAME_READER_LOOP_EN
            state_q       <= ISSUE;
            next_addr_q   <= base_q;
            issue_rem_q   <= count_q;
            deliver_rem_q <= count_q;
`else
            state_q       <= IDLE;
            busy_q        <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader: table-driven passes with a randomized SDRAM/sink and a
// queue-based reference model, plus directed stall, backpressure, zero-length and abort sequences.
`timescale 1ns/1ps
module tb_frame_reader;

   localparam int unsigned BL = 16;
   localparam int unsigned FD = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [28:0] base_address;
   logic [23:0] word_count;
   logic        busy, done;
   logic [28:0] address;
   logic [7:0]  burstcount;
   logic        read;
   logic        waitrequest;
   logic [63:0] readdata;
   logic        readdatavalid;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_ready;

   frame_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .clock(clock), .reset(reset), .start(start),
      .base_address(base_address), .word_count(word_count),
      .busy(busy), .done(done),
      .address(address), .burstcount(burstcount), .read(read),
      .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [28:0] addr;
      int unsigned len;
   } cmd_t;

   typedef struct {
      logic [28:0] base;
      int unsigned count;
      int unsigned wait_pct;
      int unsigned ready_pct;
      int unsigned beat_pct;
      int unsigned exp_bursts;
   } vec_t;

   int unsigned checks = 0;
   int unsigned failures = 0;

   cmd_t        exp_cmds[$];
   logic [63:0] exp_words[$];
   logic [28:0] pending[$];
   int unsigned issued_total, delivered, pops_in_test, pass_len, cmd_seen, done_cnt;
   int unsigned read_cycles, hold_cycles;
   bit          mon_en = 1'b0;
   bit          allow_lone_done = 1'b0;
   int unsigned wait_pct = 0, ready_pct = 100, beat_pct = 100, wait_hold = 0;
   bit          ready_low = 1'b0;
   logic        hold_v = 1'b0;
   logic [28:0] hold_addr;
   logic [7:0]  hold_bc;

   function automatic logic [63:0] pat(input logic [28:0] a);
      return {3'b101, a, 3'b010, ~a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // SDRAM slave and downstream sink, driven just after each rising edge.
   initial begin
      waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0; out_ready = 1'b0;
      forever begin
         @(posedge clock); #1;
         waitrequest = ($urandom_range(99) < wait_pct);
         if (wait_hold > 0 && read) begin
            waitrequest = 1'b1;
            wait_hold--;
         end
         if (pending.size() > 0 && $urandom_range(99) < beat_pct) begin
            readdatavalid = 1'b1;
            readdata = pat(pending.pop_front());
         end else begin
            readdatavalid = 1'b0;
            readdata = {$urandom, $urandom};
         end
         out_ready = ready_low ? 1'b0 : ($urandom_range(99) < ready_pct);
      end
   end

   // Monitor: handshakes seen here complete on the next rising edge.
   always @(negedge clock) begin
      cmd_t c;
      if (!reset) begin
         if (mon_en && hold_v) begin
            check("hold_read", read, 1);
            check("hold_address", address, hold_addr);
            check("hold_burstcount", burstcount, hold_bc);
         end
         hold_v = read && waitrequest;
         hold_addr = address;
         hold_bc = burstcount;
         if (read) read_cycles++;
         if (read && waitrequest) hold_cycles++;
         if (read && !waitrequest) begin
            for (int i = 0; i < int'(burstcount); i++) pending.push_back(address + 29'(i));
            cmd_seen++;
            issued_total += burstcount;
            if (mon_en) begin
               checks++;
               if (exp_cmds.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_cmd actual=addr %0h len %0d required=no command", address, burstcount);
               end else begin
                  c = exp_cmds.pop_front();
                  check("cmd_address", address, c.addr);
                  check("cmd_burstcount", burstcount, c.len);
                  check("credit_bound", (issued_total - delivered) <= FD, 1);
               end
            end
         end
         if (out_valid && out_ready) begin
            delivered++;
            pops_in_test++;
            if (mon_en) begin
               checks++;
               if (exp_words.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_word actual=%0h required=no word", out_data);
               end else begin
                  check("word", out_data, exp_words.pop_front());
               end
               check("done_on_last", done, (pops_in_test % pass_len) == 0);
            end
         end else if (done && mon_en && !allow_lone_done) begin
            checks++;
            failures++;
            $display("FAIL spurious_done actual=1 required=0");
         end
         if (done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic load_model(input logic [28:0] base, input int unsigned count, input int unsigned passes);
      exp_words.delete();
      exp_cmds.delete();
      for (int unsigned p = 0; p < passes; p++) begin
         for (int unsigned i = 0; i < count; i++) exp_words.push_back(pat(base + 29'(i)));
         for (int unsigned off = 0; off < count; off += BL) begin
            cmd_t c;
            c.addr = base + 29'(off);
            c.len = (count - off < BL) ? count - off : BL;
            exp_cmds.push_back(c);
         end
      end
      pass_len = (count == 0) ? 1 : count;
      pops_in_test = 0; done_cnt = 0; cmd_seen = 0;
      issued_total = 0; delivered = 0; read_cycles = 0; hold_cycles = 0;
   endtask

   task automatic pulse_start(input logic [28:0] base, input int unsigned count);
      tick();
      base_address = base;
      word_count = 24'(count);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_pass(input int unsigned count, input int unsigned bursts);
      int unsigned n = 0;
      while ((exp_words.size() > 0 || done_cnt == 0) && n < 5000) begin
         tick();
         n++;
      end
      if (n >= 5000) begin
         checks++;
         failures++;
         $display("FAIL pass_timeout actual=%0d words left required=0", exp_words.size());
      end
      @(negedge clock);
      check("pass_words", pops_in_test, count);
      check("pass_bursts", cmd_seen, bursts);
      check("pass_done_pulses", done_cnt, 1);
      check("pass_busy_low", busy, 0);
   endtask

   vec_t vecs[7];

   initial begin
      reset = 1'b1; start = 1'b0; base_address = '0; word_count = '0;
      vecs[0] = '{29'h100,       40,  0, 100, 100, 3};
      vecs[1] = '{29'h1FFFFFF8,  20, 30,  70,  60, 2};
      vecs[2] = '{29'h5,          1,  0, 100, 100, 1};
      vecs[3] = '{29'h200,       16, 50,  50,  50, 1};
      vecs[4] = '{29'h300,       17, 20,  80,  90, 2};
      vecs[5] = '{29'h1234,     100, 25,  40,  70, 7};
      vecs[6] = '{29'h1234567,  130, 10,  90,  80, 9};

      repeat (3) tick();
      reset = 1'b0;
      @(negedge clock);
      check("rst_read", read, 0);
      check("rst_address", address, 0);
      check("rst_burstcount", burstcount, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      mon_en = 1'b1;

`ifdef FRAME_READER_LOOP_EN
      begin
         int unsigned n = 0;
         load_model(29'h40, 8, 3);
         pulse_start(29'h40, 8);
         while (pops_in_test < 24 && n < 3000) begin
            tick();
            n++;
         end
         mon_en = 1'b0;
         check("loop_words", pops_in_test, 24);
         check("loop_done_pulses", done_cnt, 3);
         check("loop_busy_high", busy, 1);
         reset = 1'b1;
         tick();
         reset = 1'b0;
         @(negedge clock);
         check("loop_reset_busy", busy, 0);
         check("loop_reset_read", read, 0);
      end
`else
      for (int v = 0; v < 7; v++) begin
         wait_pct = vecs[v].wait_pct;
         ready_pct = vecs[v].ready_pct;
         beat_pct = vecs[v].beat_pct;
         load_model(vecs[v].base, vecs[v].count, 1);
         pulse_start(vecs[v].base, vecs[v].count);
         wait_pass(vecs[v].count, vecs[v].exp_bursts);
      end

      // Command held off by waitrequest for five cycles.
      wait_pct = 0; ready_pct = 100; beat_pct = 100;
      load_model(29'h400, 16, 1);
      wait_hold = 5;
      pulse_start(29'h400, 16);
      wait_pass(16, 1);
      check("hold_cycles", hold_cycles, 5);

      // Sink stalled: reads stop once the FIFO credit is used up.
      ready_low = 1'b1;
      load_model(29'h800, 200, 1);
      pulse_start(29'h800, 200);
      repeat (300) tick();
      @(negedge clock);
      check("stall_issued", issued_total, FD);
      check("stall_read_idle", read, 0);
      check("stall_out_valid", out_valid, 1);
      ready_low = 1'b0;
      wait_pass(200, 13);

      // Zero-length pass.
      allow_lone_done = 1'b1;
      load_model(29'h50, 0, 1);
      tick();
      base_address = 29'h50; word_count = '0; start = 1'b1;
      @(negedge clock);
      check("zero_done_early", done, 0);
      tick();
      start = 1'b0;
      @(negedge clock);
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      tick();
      @(negedge clock);
      check("zero_done_clear", done, 0);
      repeat (10) tick();
      check("zero_no_read", read_cycles, 0);
      allow_lone_done = 1'b0;

      // Abort with a full burst outstanding; the late beats must be dropped.
      begin
         int unsigned n = 0;
         beat_pct = 0;
         load_model(29'h900, 16, 1);
         pulse_start(29'h900, 16);
         while (cmd_seen == 0 && n < 100) begin
            tick();
            n++;
         end
         check("abort_cmd_seen", cmd_seen, 1);
         repeat (3) tick();
         mon_en = 1'b0;
         reset = 1'b1;
         tick();
         reset = 1'b0;
         @(negedge clock);
         check("abort_read", read, 0);
         check("abort_address", address, 0);
         check("abort_burstcount", burstcount, 0);
         check("abort_out_valid", out_valid, 0);
         check("abort_busy", busy, 0);
         check("abort_done", done, 0);
         load_model(29'h0, 0, 1);
         mon_en = 1'b1;
         beat_pct = 100;
         n = 0;
         while (pending.size() > 0 && n < 100) begin
            tick();
            n++;
         end
         repeat (5) tick();
         @(negedge clock);
         check("abort_stale_pending", pending.size(), 0);
         check("abort_stale_words", pops_in_test, 0);
         check("abort_stale_valid", out_valid, 0);
         load_model(29'hA00, 4, 1);
         pulse_start(29'hA00, 4);
         wait_pass(4, 1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
